// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM burst reader.
package bram_reader_pkg;

  typedef enum logic {IDLE, READ} state_t;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_rd_fifo.sv
// Two-entry synchronous FIFO; absorbs BRAM read latency under output backpressure.
module bram_rd_fifo
  import bram_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count != 2'(FIFO_DEPTH));
  assign do_pop   = pop && (count != 2'd0);
  assign empty    = (count == 2'd0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst reader: issues sequential BRAM reads and streams the words out with a last marker.
module bram_burst_reader
  import bram_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_ready,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  pending;
  logic                  pending_last;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;

  assign cmd_ready = (state == IDLE) && mem_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = out_valid && out_ready;
  assign busy      = (state == READ);

  // Words already read but not yet consumed, counting this cycle's pop as gone.
  assign occupancy = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};
  assign issue     = (state == READ) && (remaining != '0) && (occupancy < 3'(FIFO_DEPTH));

  assign mem_rd_addr           = addr;
  assign out_valid             = !fifo_empty;
  assign {out_last, out_data}  = fifo_head;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && (cmd_len != '0)) state_next = READ;
      READ: if (pop && out_last)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr         <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      if (accept) begin
        addr      <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      pending      <= issue;
      pending_last <= issue && (remaining == (ADDR_WIDTH+1)'(1));
    end
  end

  bram_rd_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pending),
    .push_data ({pending_last, mem_rd_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader with a behavioural BRAM and stream model.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  bram_burst_reader #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_ready   (mem_ready),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  logic [31:0] bram [256];
  always @(posedge clk) mem_rd_data <= bram[mem_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output readiness pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  int ready_mode = 0;
  int ready_idx  = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
          ready_idx++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic [32:0] sb [$];
  logic [32:0] held;
  logic        hold_pending = 1'b0;
  logic        accept_seen  = 1'b0;
  logic [7:0]  prev_addr    = '0;
  int          issued       = 0;
  int          popped       = 0;

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
      accept_seen  = 1'b0;
      prev_addr    = '0;
      issued       = 0;
      popped       = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_last, out_data}), 64'(held));
      end
      hold_pending = out_valid && !out_ready;
      held         = {out_last, out_data};

      if (accept_seen) begin
        prev_addr   = mem_rd_addr;
        issued      = 0;
        popped      = 0;
        accept_seen = 1'b0;
      end else if (mem_rd_addr != prev_addr) begin
        logic [7:0] nxt;
        nxt = prev_addr + 8'd1;
        check("rd_addr_step", 64'(mem_rd_addr), 64'(nxt));
        prev_addr = mem_rd_addr;
        issued++;
        check("occupancy_le2", 64'((issued - popped) <= 2), 64'd1);
      end

      if (out_valid && out_ready) begin
        popped++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", {out_last, out_data}, $time);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("word", 64'({out_last, out_data}), 64'(e));
        end
      end

      if (cmd_valid && cmd_ready) begin
        int base;
        int n;
        base = int'(cmd_addr);
        n    = int'(cmd_len);
        for (int k = 0; k < n; k++)
          sb.push_back({(k == n - 1) ? 1'b1 : 1'b0, bram[(base + k) % 256]});
        accept_seen = 1'b1;
      end
    end
  end

  task automatic issue_cmd(input int a, input int l);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 8'(a);
    cmd_len   = 9'(l);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit toggle_mr);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (toggle_mr) mem_ready = 1'($urandom_range(0, 1));
      if (!busy && !out_valid && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    mem_ready = 1'b1;
    check("burst_done", 64'(done), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] addr_hold;
    for (int i = 0; i < 256; i++) bram[i] = 32'(i + 100);
    reset     = 1'b1;
    mem_ready = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Basic burst: latency, ordering, last marker, busy release.
    ready_mode = 0;
    issue_cmd(4, 4);
    @(negedge clk); check("lat_t1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_t2", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_t3", 64'(out_valid), 64'd1);
    check("first_word", 64'({out_last, out_data}), 64'({1'b0, 32'd104}));
    repeat (3) @(negedge clk);
    check("last_word", 64'({out_last, out_data}), 64'({1'b1, 32'd107}));
    check("busy_at_last", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_fall", 64'(busy), 64'd0);
    wait_done(50, 1'b0);

    // Backpressure pattern.
    ready_mode = 1;
    ready_idx  = 0;
    issue_cmd(4, 4);
    wait_done(100, 1'b0);
    ready_mode = 0;

    // Address wrap.
    issue_cmd(254, 4);
    wait_done(50, 1'b0);

    // Full sweep with no bubbles.
    issue_cmd(0, 256);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("sweep_start", 64'(seen), 64'd1);
      for (int k = 0; k < 256; k++) begin
        if (k > 0) @(negedge clk);
        check("sweep_no_bubble", 64'(out_valid), 64'd1);
        if (k == 255) check("sweep_last", 64'({out_last, out_data}), 64'({1'b1, 32'd355}));
      end
    end
    wait_done(50, 1'b0);

    // Reset with the third word in flight.
    issue_cmd(0, 8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_rd_addr", 64'(mem_rd_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("no_stale", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    issue_cmd(10, 1);
    repeat (3) @(negedge clk);
    check("post_reset_word", 64'({out_valid, out_last, out_data}), 64'({1'b1, 1'b1, 32'd110}));
    wait_done(50, 1'b0);

    // Commands gated by mem_ready.
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 8'd50;
    cmd_len   = 9'd2;
    @(negedge clk);
    addr_hold = mem_rd_addr;
    for (int i = 0; i < 5; i++) begin
      check("gated_cmd_ready", 64'(cmd_ready), 64'd0);
      check("gated_busy", 64'(busy), 64'd0);
      check("gated_rd_addr", 64'(mem_rd_addr), 64'(addr_hold));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("accept_same_cycle", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(50, 1'b0);

    // Zero-length command.
    issue_cmd(77, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("len0_busy", 64'(busy), 64'd0);
      check("len0_out_valid", 64'(out_valid), 64'd0);
    end
    check("len0_cmd_ready", 64'(cmd_ready), 64'd1);

    // Randomized bursts with random backpressure and mem_ready toggling.
    ready_mode = 2;
    for (int t = 0; t < 25; t++) begin
      int a;
      int l;
      int r;
      a = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 9));
      if (r == 0)      l = 0;
      else if (r == 1) l = int'($urandom_range(100, 256));
      else             l = int'($urandom_range(1, 20));
      issue_cmd(a, l);
      wait_done(20 * l + 50, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
